branch_ctrl: RTL and testbench
==============================

// Module: branch_ctrl
// PURPOSE
//  Decode-stage branch sequencer for the MIPS core. It holds the decoder while a branch's operands are not ready.
//  It then resolves the branch through the existing compare unit and presents a registered redirect to fetch under a valid/ack handshake.
//  It also emits the $31 link write for BGEZAL/BLTZAL.
// PARAMETERS
//  LINK_REG  5'd31  GPR written by BGEZAL/BLTZAL
//  CNT_W     32     width of the statistics counters (only with BRANCH_STATS_EN)
// PORTS
//  clk           in   1   core clock; all state updates on rising edge
//  resetn        in   1   asynchronous, active-low reset
//  br_valid_d    in   1   decode holds a conditional branch (BEQ/BNE/BGTZ/BLEZ/REGIMM)
//  op_d          in   6   instruction opcode
//  rt_d          in   5   rt field (REGIMM sub-op)
//  pc_d          in   32  PC of the branch
//  imm_d         in   16  branch offset
//  rs_val/rt_val in   32  forwarded operand values
//  rs_rdy/rt_rdy in   1   hazard unit: operand value is final this cycle
//  flush         in   1   exception/ERET flush; abandons any branch in progress
//  redir_ack     in   1   fetch has accepted the redirect
//  stall_d       out  1   hold decode and fetch
//  redir_valid   out  1   redirect pending
//  redir_taken   out  1   1 = go to redir_pc; 0 = fall through (pc_d+8)
//  redir_pc      out  32  resolved next PC after the delay slot
//  link_we       out  1   one-cycle write strobe for LINK_REG
//  link_wa       out  5   = LINK_REG
//  link_wd       out  32  pc_d+8
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except link_wa=LINK_REG.
//  IDLE: br_valid_d & operands ready -> RESOLVE; br_valid_d & not ready -> WAIT.
//   Operands ready = rs_rdy, plus rt_rdy for BEQ/BNE only.
//  WAIT: stall_d=1. Move to RESOLVE in the cycle the operands become ready. A branch may remain in WAIT indefinitely.
//  RESOLVE (1 cycle):
//   - stall_d=1; operands and pc_d are latched.
//   - taken is computed by compare; the target is computed.
//   - Next state: REDIRECT.
//  REDIRECT:
//   - redir_valid=1 with redir_taken/redir_pc held stable until redir_ack.
//   - The cycle with redir_ack: stall_d=0, next state IDLE. A back-to-back branch is accepted from IDLE the next cycle.
//   - Branch-to-redirect latency with ready operands: 2 cycles + ack wait.
//  Target: pc_d + 4 + (sext(imm_d) << 2), modulo 2^32 (wraps silently). Fall-through: pc_d + 8.
//  Link: link_we pulses exactly once, in the RESOLVE cycle, for BGEZAL/BLTZAL, independent of taken.
//  Unknown op with br_valid_d: resolves as not-taken; no link write.
//  flush: has priority over all other events in any state.
//   - Next state IDLE; redir_valid/stall_d/link_we drop next cycle.
//   - If RESOLVE and flush coincide, link_we is suppressed.
//  Reset mid-operation: immediately IDLE; pending redirect and stall are lost.
// CONFIGURATION
//  BRANCH_STATS_EN defined:
//   - adds outputs stat_br (branches resolved) and stat_tk (branches taken), both CNT_W bits, saturating.
//   - Counters increment on the RESOLVE cycle, except when flush is asserted in that cycle. Reset to 0.
//  BRANCH_STATS_EN not defined: no counters and no stat ports; behaviour otherwise identical.
// STRUCTURE
//  defines.vh:
//   - existing EXE_BEQ/BNE/BGTZ/BLEZ/BGEZ/BLTZ/BGEZAL/BLTZAL codes
//   - new BR_IDLE/BR_WAIT/BR_RESOLVE/BR_REDIRECT 2-bit state encodings
//   - REGIMM opcode 6'b000001
//  Sub-module: one instance of compare (a=rs latch, b=rt latch, op, rt). The controller adds no comparison logic of its own.
// TESTING
//  1. BEQ, pc=0x00400000, imm=0x0004, rs=rt=5, both rdy, ack same cycle as redir_valid
//     -> redir_valid in cycle 2, taken=1, redir_pc=0x00400014; stall_d high for 2 cycles.
//  2. BNE, rs=rt=7, rt_rdy low 3 cycles
//     -> stall_d high for 3 wait cycles + RESOLVE; then taken=0, redir_pc=0x00400008.
//  3. BLTZAL, rs=0xFFFFFFFF, pc=0x1000
//     -> link_we one pulse with link_wd=0x1008, link_wa=31; taken=1.
//     Repeat with rs=1: link_we still pulses, taken=0.
//  4. BGTZ, pc=0xFFFFFFF0, imm=0x0004
//     -> redir_pc=0x00000004 (wrap).
//     With imm=0xFFFF: redir_pc=0xFFFFFFF0.
//  5. Hold redir_ack low 4 cycles in REDIRECT -> redir_* stable.
//     flush in the 3rd cycle -> IDLE next cycle; redir_valid=0; no ack needed.
//  6. resetn low during WAIT -> all outputs 0 asynchronously.
//     With BRANCH_STATS_EN: 10 branches resolved, 6 taken -> stat_br=10, stat_tk=6.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_ctrl_pkg
// Shared definitions for the decode-stage branch sequencer:
//   - MIPS branch opcode / REGIMM sub-op codes
//   - branch sequencer state encoding
//   - small decode helpers (operand usage, link detection, target address)
// Optional feature macro used by the top: BRANCH_STATS_EN
// ---------------------------------------------------------------------------
package branch_ctrl_pkg;

    localparam logic [4:0] LINK_REG_DEF = 5'd31;
    localparam int         CNT_W_DEF    = 32;

    // Primary opcodes
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] EXE_BEQ   = 6'b000100;
    localparam logic [5:0] EXE_BNE   = 6'b000101;
    localparam logic [5:0] EXE_BLEZ  = 6'b000110;
    localparam logic [5:0] EXE_BGTZ  = 6'b000111;

    // REGIMM sub-ops carried in the rt field
    localparam logic [4:0] EXE_BLTZ   = 5'b00000;
    localparam logic [4:0] EXE_BGEZ   = 5'b00001;
    localparam logic [4:0] EXE_BLTZAL = 5'b10000;
    localparam logic [4:0] EXE_BGEZAL = 5'b10001;

    typedef enum logic [1:0] {
        BR_IDLE     = 2'd0,
        BR_WAIT     = 2'd1,
        BR_RESOLVE  = 2'd2,
        BR_REDIRECT = 2'd3
    } br_state_e;

    // Only the two-register compares need the rt operand to be final.
    function automatic logic f_uses_rt(input logic [5:0] op);
        return (op == EXE_BEQ) || (op == EXE_BNE);
    endfunction

    function automatic logic f_is_link(input logic [5:0] op, input logic [4:0] rt);
        return (op == OP_REGIMM) && ((rt == EXE_BLTZAL) || (rt == EXE_BGEZAL));
    endfunction

    // Branch target relative to the delay slot; wraps modulo 2^32.
    function automatic logic [31:0] f_target(input logic [31:0] pc, input logic [15:0] imm);
        return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/branch_ctrl_compare.sv
// ---------------------------------------------------------------------------
// branch_ctrl_compare
// Branch condition evaluator. Purely combinational.
// Ports:
//   i_a     in  32  rs operand
//   i_b     in  32  rt operand
//   i_op    in  6   opcode
//   i_rt    in  5   rt field (REGIMM sub-op)
//   o_taken out 1   branch condition true; 0 for unknown ops
// ---------------------------------------------------------------------------
module branch_ctrl_compare
    import branch_ctrl_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [5:0]  i_op,
    input  logic [4:0]  i_rt,
    output logic        o_taken
);

    // Condition decode; unknown encodings fall through to not-taken
    always_comb begin
        o_taken = 1'b0;
        case (i_op)
            EXE_BEQ:  o_taken = (i_a == i_b);
            EXE_BNE:  o_taken = (i_a != i_b);
            EXE_BLEZ: o_taken = i_a[31] | (i_a == 32'd0);
            EXE_BGTZ: o_taken = ~i_a[31] & (i_a != 32'd0);
            OP_REGIMM: begin
                case (i_rt)
                    EXE_BLTZ, EXE_BLTZAL: o_taken = i_a[31];
                    EXE_BGEZ, EXE_BGEZAL: o_taken = ~i_a[31];
                    default:              o_taken = 1'b0;
                endcase
            end
            default:  o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ctrl
// Decode-stage branch sequencer: holds decode until branch operands are
// final, resolves the branch through branch_ctrl_compare, and presents a
// registered redirect to fetch under a valid/ack handshake. Emits the link
// register write for BGEZAL/BLTZAL in the resolve cycle.
// Optional feature: define BRANCH_STATS_EN to add saturating counters
// stat_br (branches resolved) and stat_tk (branches taken).
// Ports:
//   clk, resetn            clock, async active-low reset
//   br_valid_d, op_d, rt_d, pc_d, imm_d   branch in decode
//   rs_val, rt_val, rs_rdy, rt_rdy        forwarded operands + readiness
//   flush                  abandon any branch in progress
//   redir_ack              fetch accepted the redirect
//   stall_d                hold decode and fetch
//   redir_valid/taken/pc   redirect to fetch
//   link_we/wa/wd          link register write
//   stat_br, stat_tk       statistics (BRANCH_STATS_EN only)
// ---------------------------------------------------------------------------
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter logic [4:0] LINK_REG = LINK_REG_DEF
`ifdef BRANCH_STATS_EN
    , parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        br_valid_d,
    input  logic [5:0]  op_d,
    input  logic [4:0]  rt_d,
    input  logic [31:0] pc_d,
    input  logic [15:0] imm_d,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rs_rdy,
    input  logic        rt_rdy,
    input  logic        flush,
    input  logic        redir_ack,
    output logic        stall_d,
    output logic        redir_valid,
    output logic        redir_taken,
    output logic [31:0] redir_pc,
    output logic        link_we,
    output logic [4:0]  link_wa,
    output logic [31:0] link_wd
`ifdef BRANCH_STATS_EN
    , output logic [CNT_W-1:0] stat_br
    , output logic [CNT_W-1:0] stat_tk
`endif
);

    br_state_e   r_state;
    br_state_e   w_state_nxt;
    logic        w_ops_rdy;
    logic        w_latch;
    logic        w_taken;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_pc;
    logic [15:0] r_imm;
    logic [5:0]  r_op;
    logic [4:0]  r_rt;

    logic        r_stall;
    logic        r_redir_valid;
    logic        r_redir_taken;
    logic [31:0] r_redir_pc;
    logic        r_link_pend;
    logic [31:0] r_link_wd;

    // Next-state decode; flush overrides every other event
    always_comb begin
        w_state_nxt = r_state;
        w_ops_rdy   = rs_rdy & (~f_uses_rt(op_d) | rt_rdy);
        if (flush) begin
            w_state_nxt = BR_IDLE;
        end else begin
            case (r_state)
                BR_IDLE: begin
                    if (br_valid_d) begin
                        w_state_nxt = w_ops_rdy ? BR_RESOLVE : BR_WAIT;
                    end else begin
                        w_state_nxt = BR_IDLE;
                    end
                end
                BR_WAIT:     w_state_nxt = w_ops_rdy ? BR_RESOLVE : BR_WAIT;
                BR_RESOLVE:  w_state_nxt = BR_REDIRECT;
                BR_REDIRECT: w_state_nxt = redir_ack ? BR_IDLE : BR_REDIRECT;
                default:     w_state_nxt = BR_IDLE;
            endcase
        end
    end

    // Operands are captured in the cycle they become final, so the compare
    // in RESOLVE sees stable values regardless of forwarding changes.
    assign w_latch = (w_state_nxt == BR_RESOLVE);

    branch_ctrl_compare u_compare (
        .i_a     (r_a),
        .i_b     (r_b),
        .i_op    (r_op),
        .i_rt    (r_rt),
        .o_taken (w_taken)
    );

    // State, operand capture and registered redirect/link outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= BR_IDLE;
            r_a           <= 32'd0;
            r_b           <= 32'd0;
            r_pc          <= 32'd0;
            r_imm         <= 16'd0;
            r_op          <= 6'd0;
            r_rt          <= 5'd0;
            r_stall       <= 1'b0;
            r_redir_valid <= 1'b0;
            r_redir_taken <= 1'b0;
            r_redir_pc    <= 32'd0;
            r_link_pend   <= 1'b0;
            r_link_wd     <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_stall     <= (w_state_nxt != BR_IDLE);
            r_link_pend <= w_latch & f_is_link(op_d, rt_d);
            if (w_latch) begin
                r_a       <= rs_val;
                r_b       <= rt_val;
                r_pc      <= pc_d;
                r_imm     <= imm_d;
                r_op      <= op_d;
                r_rt      <= rt_d;
                r_link_wd <= pc_d + 32'd8;
            end else begin
                r_a       <= r_a;
            end
            if (flush) begin
                r_redir_valid <= 1'b0;
            end else if (r_state == BR_RESOLVE) begin
                r_redir_valid <= 1'b1;
                r_redir_taken <= w_taken;
                r_redir_pc    <= w_taken ? f_target(r_pc, r_imm) : (r_pc + 32'd8);
            end else if ((r_state == BR_REDIRECT) && redir_ack) begin
                r_redir_valid <= 1'b0;
            end else begin
                r_redir_valid <= r_redir_valid;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] r_stat_br;
    logic [CNT_W-1:0] r_stat_tk;

    // Saturating resolve/taken counters; a flushed resolve is not counted
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stat_br <= {CNT_W{1'b0}};
            r_stat_tk <= {CNT_W{1'b0}};
        end else if ((r_state == BR_RESOLVE) && !flush) begin
            if (r_stat_br != {CNT_W{1'b1}}) begin
                r_stat_br <= r_stat_br + CNT_W'(1);
            end else begin
                r_stat_br <= r_stat_br;
            end
            if (w_taken && (r_stat_tk != {CNT_W{1'b1}})) begin
                r_stat_tk <= r_stat_tk + CNT_W'(1);
            end else begin
                r_stat_tk <= r_stat_tk;
            end
        end else begin
            r_stat_br <= r_stat_br;
            r_stat_tk <= r_stat_tk;
        end
    end

    assign stat_br = r_stat_br;
    assign stat_tk = r_stat_tk;
`endif

    assign stall_d     = r_stall;
    assign redir_valid = r_redir_valid;
    assign redir_taken = r_redir_taken;
    assign redir_pc    = r_redir_pc;
    // The pending link write is registered; a coincident flush squashes it.
    assign link_we     = r_link_pend & ~flush;
    assign link_wa     = LINK_REG;
    assign link_wd     = r_link_wd;

endmodule

// File: tb/tb_branch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_ctrl
// Self-checking bench for branch_ctrl: directed scenarios plus randomized
// branches checked cycle by cycle against a behavioural reference model.
// Define BRANCH_STATS_EN to also check the statistics counters.
// ---------------------------------------------------------------------------
module tb_branch_ctrl;

    localparam logic [5:0] T_REGIMM = 6'b000001;
    localparam logic [5:0] T_BEQ    = 6'b000100;
    localparam logic [5:0] T_BNE    = 6'b000101;
    localparam logic [5:0] T_BLEZ   = 6'b000110;
    localparam logic [5:0] T_BGTZ   = 6'b000111;
    localparam logic [5:0] T_UNK    = 6'b000010;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        br_valid_d = 1'b0;
    logic [5:0]  op_d = 6'd0;
    logic [4:0]  rt_d = 5'd0;
    logic [31:0] pc_d = 32'd0;
    logic [15:0] imm_d = 16'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        rs_rdy = 1'b0;
    logic        rt_rdy = 1'b0;
    logic        flush = 1'b0;
    logic        redir_ack = 1'b0;
    logic        stall_d;
    logic        redir_valid;
    logic        redir_taken;
    logic [31:0] redir_pc;
    logic        link_we;
    logic [4:0]  link_wa;
    logic [31:0] link_wd;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br;
    logic [31:0] stat_tk;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int m_res   = 0;
    int m_tk    = 0;

    branch_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .br_valid_d  (br_valid_d),
        .op_d        (op_d),
        .rt_d        (rt_d),
        .pc_d        (pc_d),
        .imm_d       (imm_d),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .rs_rdy      (rs_rdy),
        .rt_rdy      (rt_rdy),
        .flush       (flush),
        .redir_ack   (redir_ack),
        .stall_d     (stall_d),
        .redir_valid (redir_valid),
        .redir_taken (redir_taken),
        .redir_pc    (redir_pc),
        .link_we     (link_we),
        .link_wa     (link_wa),
        .link_wd     (link_wd)
`ifdef BRANCH_STATS_EN
        , .stat_br   (stat_br)
        , .stat_tk   (stat_tk)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: branch condition from signed arithmetic
    function automatic logic m_taken(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [31:0] rs, input logic [31:0] rtv);
        int signed s;
        s = $signed(rs);
        case (op)
            T_BEQ:  return rs == rtv;
            T_BNE:  return rs != rtv;
            T_BLEZ: return s <= 0;
            T_BGTZ: return s > 0;
            T_REGIMM: begin
                if (rt == 5'd0 || rt == 5'd16) return s < 0;
                else if (rt == 5'd1 || rt == 5'd17) return s >= 0;
                else return 1'b0;
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc, input logic [15:0] imm);
        int signed off;
        off = $signed(imm);
        return pc + 32'd4 + 32'(off * 4);
    endfunction

    // Drive one branch and check every cycle until one idle cycle after it.
    // rs_dl/rt_dl: cycle at which each operand becomes ready; ack_dl: cycles
    // of redirect before ack; fl: cycle with flush (-1 none).
    task automatic do_branch(input logic [5:0] op, input logic [4:0] rtf,
                             input logic [31:0] pc, input logic [15:0] imm,
                             input logic [31:0] rs, input logic [31:0] rtv,
                             input int rs_dl, input int rt_dl, input int ack_dl, input int fl);
        int r;
        int e;
        int f;
        logic res;
        logic tk;
        logic lk;
        logic [31:0] exp_pc;
        f = fl;
        r = ((op == T_BEQ) || (op == T_BNE)) ? ((rs_dl > rt_dl) ? rs_dl : rt_dl) : rs_dl;
        if (f > r + 2 + ack_dl) f = -1;
        e   = (f >= 0) ? f : (r + 2 + ack_dl);
        res = (f < 0) || (f > r + 1);
        tk  = m_taken(op, rtf, rs, rtv);
        lk  = res && (op == T_REGIMM) && (rtf == 5'd16 || rtf == 5'd17);
        exp_pc = tk ? m_target(pc, imm) : (pc + 32'd8);
        if (res) begin
            m_res++;
            if (tk) m_tk++;
        end
        for (int c = 0; c <= e + 1; c++) begin
            @(negedge clk);
            br_valid_d = (c <= e);
            op_d       = op;
            rt_d       = rtf;
            pc_d       = pc;
            imm_d      = imm;
            rs_val     = rs;
            rt_val     = rtv;
            rs_rdy     = (c >= rs_dl);
            rt_rdy     = (c >= rt_dl);
            flush      = (c == f);
            redir_ack  = (f < 0) && (c == e);
            #1;
            check_val("stall_d", 32'(stall_d), 32'((c >= 1) && (c <= e)));
            check_val("redir_valid", 32'(redir_valid), 32'(res && (c >= r + 2) && (c <= e)));
            check_val("link_we", 32'(link_we), 32'(lk && (c == r + 1)));
            if (res && (c >= r + 2) && (c <= e)) begin
                check_val("redir_taken", 32'(redir_taken), 32'(tk));
                check_val("redir_pc", redir_pc, exp_pc);
            end
            if (lk && (c == r + 1)) begin
                check_val("link_wd", link_wd, pc + 32'd8);
                check_val("link_wa", 32'(link_wa), 32'd31);
            end
        end
        flush     = 1'b0;
        redir_ack = 1'b0;
    endtask

    initial begin
        logic [5:0]  op;
        logic [4:0]  rtf;
        logic [31:0] rs;
        logic [31:0] rtv;
        int          fl;

        // Reset state
        #2;
        check_val("rst_stall", 32'(stall_d), 32'd0);
        check_val("rst_rvalid", 32'(redir_valid), 32'd0);
        check_val("rst_pc", redir_pc, 32'd0);
        check_val("rst_link_we", 32'(link_we), 32'd0);
        check_val("rst_link_wa", 32'(link_wa), 32'd31);
        check_val("rst_link_wd", link_wd, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Directed scenarios
        do_branch(T_BEQ, 5'd0, 32'h0040_0000, 16'h0004, 32'd5, 32'd5, 0, 0, 0, -1);
        check_val("t1_pc_const", redir_pc, 32'h0040_0014);
        do_branch(T_BNE, 5'd0, 32'h0040_0000, 16'h0004, 32'd7, 32'd7, 0, 3, 0, -1);
        check_val("t2_pc_const", redir_pc, 32'h0040_0008);
        do_branch(T_REGIMM, 5'd16, 32'h0000_1000, 16'h0010, 32'hFFFF_FFFF, 32'd0, 0, 0, 1, -1);
        do_branch(T_REGIMM, 5'd16, 32'h0000_1000, 16'h0010, 32'd1, 32'd0, 1, 0, 0, -1);
        do_branch(T_BGTZ, 5'd0, 32'hFFFF_FFF0, 16'h0004, 32'd1, 32'd0, 0, 0, 0, -1);
        check_val("t4_wrap_const", redir_pc, 32'h0000_0004);
        do_branch(T_BGTZ, 5'd0, 32'hFFFF_FFF0, 16'hFFFF, 32'd3, 32'd0, 0, 0, 0, -1);
        check_val("t4_neg_const", redir_pc, 32'hFFFF_FFF0);
        do_branch(T_REGIMM, 5'd1, 32'h0000_2000, 16'h0100, 32'd9, 32'd0, 0, 0, 4, -1);
        do_branch(T_REGIMM, 5'd1, 32'h0000_2000, 16'h0100, 32'd9, 32'd0, 0, 0, 4, 4);
        do_branch(T_REGIMM, 5'd17, 32'h0000_3000, 16'h0008, 32'd0, 32'd0, 1, 0, 0, 2);
        do_branch(T_BEQ, 5'd0, 32'h0000_4000, 16'h0008, 32'd1, 32'd1, 2, 0, 0, 1);
        do_branch(T_UNK, 5'd16, 32'h0000_5000, 16'h0008, 32'd0, 32'd0, 0, 0, 0, -1);
        do_branch(T_BLEZ, 5'd0, 32'h0000_6000, 16'h8000, 32'd0, 32'd0, 0, 5, 0, -1);

        // Randomized branches
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: op = T_BEQ;
                1: op = T_BNE;
                2: op = T_BLEZ;
                3: op = T_BGTZ;
                4: op = T_REGIMM;
                default: op = T_UNK;
            endcase
            case ($urandom_range(0, 4))
                0: rtf = 5'd0;
                1: rtf = 5'd1;
                2: rtf = 5'd16;
                3: rtf = 5'd17;
                default: rtf = 5'($urandom);
            endcase
            rtv = $urandom;
            case ($urandom_range(0, 3))
                0: rs = 32'd0;
                1: rs = $urandom;
                2: rs = rtv;
                default: rs = 32'h8000_0000 | $urandom;
            endcase
            fl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 6)) : -1;
            do_branch(op, rtf, $urandom, 16'($urandom), rs, rtv,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), fl);
        end

`ifdef BRANCH_STATS_EN
        check_val("stat_br", stat_br, 32'(m_res));
        check_val("stat_tk", stat_tk, 32'(m_tk));
`endif

        // Reset while a branch waits for operands
        @(negedge clk);
        br_valid_d = 1'b1;
        op_d       = T_BEQ;
        rs_rdy     = 1'b0;
        rt_rdy     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_val("wait_stall", 32'(stall_d), 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        check_val("arst_stall", 32'(stall_d), 32'd0);
        check_val("arst_rvalid", 32'(redir_valid), 32'd0);
        check_val("arst_link_we", 32'(link_we), 32'd0);
        check_val("arst_link_wa", 32'(link_wa), 32'd31);
`ifdef BRANCH_STATS_EN
        check_val("arst_stat_br", stat_br, 32'd0);
`endif
        @(negedge clk);
        br_valid_d = 1'b0;
        resetn     = 1'b1;
        @(negedge clk);
        #1;
        check_val("post_rst_stall", 32'(stall_d), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
